// File: rtl/fixed_clamp_pack.sv
// rtl/fixed_clamp_pack.sv - clamp signed samples to unsigned lanes and pack PACK lanes per word
// Optional clamp statistic counter enabled by FIXED_CLAMP_PACK_STATS_EN.
module fixed_clamp_pack #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int PACK      = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [IN_WIDTH-1:0]       s_axis_a_tdata,
    input  logic                      s_axis_a_tvalid,
    input  logic                      s_axis_a_tlast,
    output logic                      s_axis_a_tready,
    output logic [OUT_WIDTH*PACK-1:0] m_axis_result_tdata,
    output logic                      m_axis_result_tlast,
    output logic                      m_axis_result_tvalid,
    input  logic                      m_axis_result_tready
`ifdef FIXED_CLAMP_PACK_STATS_EN
    ,
    output logic [31:0]               clamp_count
`endif
);

    localparam int LW = $clog2(PACK);

    logic                 c_valid;
    logic                 c_last;
    logic [OUT_WIDTH-1:0] c_data;
    logic [OUT_WIDTH-1:0] acc [PACK-1];
    logic [LW-1:0]        lane;

    logic                      s_hs;
    logic                      neg;
    logic                      over;
    logic                      clamp;
    logic [OUT_WIDTH-1:0]      clamped;
    logic                      completing;
    logic                      out_free;
    logic                      c_take;
    logic [OUT_WIDTH*PACK-1:0] word;

    assign neg = s_axis_a_tdata[IN_WIDTH-1];

    // Non-negative samples overflow when any bit above the lane width is set.
    generate
        if (IN_WIDTH > OUT_WIDTH + 1) begin : g_over
            assign over = !neg && (|s_axis_a_tdata[IN_WIDTH-2:OUT_WIDTH]);
        end else begin : g_no_over
            assign over = 1'b0;
        end
    endgenerate

    assign clamp   = neg || over;
    assign clamped = neg ? '0 : (over ? '1 : s_axis_a_tdata[OUT_WIDTH-1:0]);

    assign completing      = (lane == LW'(PACK - 1)) || c_last;
    assign out_free        = !m_axis_result_tvalid || m_axis_result_tready;
    assign c_take          = c_valid && (!completing || out_free);
    assign s_axis_a_tready = !c_valid || c_take;
    assign s_hs            = s_axis_a_tvalid && s_axis_a_tready;

    always_comb begin
        word = '0;
        for (int i = 0; i < PACK - 1; i++) begin
            if (LW'(i) < lane) word[i*OUT_WIDTH +: OUT_WIDTH] = acc[i];
        end
        for (int i = 0; i < PACK; i++) begin
            if (LW'(i) == lane) word[i*OUT_WIDTH +: OUT_WIDTH] = c_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            c_valid              <= 1'b0;
            c_last               <= 1'b0;
            c_data               <= '0;
            lane                 <= '0;
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tlast  <= 1'b0;
            m_axis_result_tdata  <= '0;
            for (int i = 0; i < PACK - 1; i++) acc[i] <= '0;
        end else begin
            if (s_hs) begin
                c_data  <= clamped;
                c_last  <= s_axis_a_tlast;
                c_valid <= 1'b1;
            end else if (c_take) begin
                c_valid <= 1'b0;
            end

            if (m_axis_result_tvalid && m_axis_result_tready) m_axis_result_tvalid <= 1'b0;

            if (c_take) begin
                if (completing) begin
                    m_axis_result_tdata  <= word;
                    m_axis_result_tlast  <= c_last;
                    m_axis_result_tvalid <= 1'b1;
                    lane                 <= '0;
                    for (int i = 0; i < PACK - 1; i++) acc[i] <= '0;
                end else begin
                    for (int i = 0; i < PACK - 1; i++) begin
                        if (lane == LW'(i)) acc[i] <= c_data;
                    end
                    lane <= lane + LW'(1);
                end
            end
        end
    end

`ifdef FIXED_CLAMP_PACK_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            clamp_count <= '0;
        end else if (s_hs && clamp && (clamp_count != '1)) begin
            clamp_count <= clamp_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fixed_clamp_pack.md
# fixed_clamp_pack

Downstream consumer of the float-to-fixed converter. It takes the signed fixed-point integer stream, clamps each sample to an unsigned OUT_WIDTH range, and packs PACK consecutive samples into one wide output word for the pixel/memory write path. AXI-stream in and out. A partial word is absorbed and flushed on tlast, so the converter is not stalled while the sink is busy.

## Interface
- IN_WIDTH, 32: signed input sample width.
- OUT_WIDTH, 8: unsigned clamped lane width.
- PACK, 4: lanes per output word; must be at least 2.
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; synchronous, active-low.
- s_axis_a_tdata  in  IN_WIDTH  signed two's-complement sample.
- s_axis_a_tvalid  in  1  sample valid.
- s_axis_a_tlast  in  1  last sample of a packet; forces a flush.
- s_axis_a_tready  out  1  block accepts the sample this cycle.
- m_axis_result_tdata  out  OUT_WIDTH*PACK  packed word; lane 0 is in the LSBs.
- m_axis_result_tlast  out  1  word holds the tlast sample.
- m_axis_result_tvalid  out  1  word valid.
- m_axis_result_tready  in  1  sink accepts the word.
- clamp_count  out  32  clamp statistic; present only with the macro (see Configuration).

## Operation
- Stage C (clamp register), loaded on s-handshake:
  - x < 0 → 0.
  - x > 2^OUT_WIDTH−1 → 2^OUT_WIDTH−1.
  - Otherwise x[OUT_WIDTH−1:0].
  - Also registers tlast and c_valid.
- Accumulator: PACK−1 lanes plus lane counter `lane` (0..PACK−1).
- Completing sample: lane==PACK−1 or tlast==1.
- out_free = !m_axis_result_tvalid || m_axis_result_tready.
- c_take = c_valid && (!completing || out_free).
- s_axis_a_tready = !c_valid || c_take (combinational).
- Non-completing take: write the value into accumulator lane `lane`; lane++.
- Completing take:
  - Output register ← accumulator lanes 0..lane−1, the new value in lane `lane`, and zeros in all higher lanes.
  - tvalid ← 1; tlast ← the sample's tlast.
  - Accumulator cleared; lane ← 0.
- Output register keeps tdata and tlast stable while tvalid && !tready.
- tvalid falls after the handshake unless a new completing take happens in the same cycle.
- Reset (synchronous, aresetn==0 at the edge), including mid-operation:
  - c_valid, m_axis_result_tvalid, m_axis_result_tlast and lane go to 0.
  - m_axis_result_tdata and the accumulator clear to 0.
  - Any partial word is discarded.
  - s_axis_a_tready reads 1 during and after reset.
- Simultaneous output handshake and completing take: the output register reloads that cycle, so there is no bubble.
- tlast with lane==0 emits a single-lane word.

## Timing
- Sample accepted at edge T is in stage C after T.
- If it completes a word and out_free holds, the word is valid after edge T+1 (2-cycle latency).
- Throughput: 1 sample/cycle sustained; up to 1 word/cycle when every sample carries tlast.
- Output stalled: the block absorbs up to PACK−1 samples into the accumulator plus 1 in stage C, then s_axis_a_tready drops.
- Any output, or the accumulator, may change only at a clock edge.

## Configuration
- FIXED_CLAMP_PACK_STATS_EN defined:
  - Port clamp_count exists.
  - Increments by 1 on each s-handshake whose sample gets clamped (either bound).
  - Saturates at 2^32−1.
  - Resets to 0.
- Not defined: the port and its counter logic are absent; all other behaviour is identical.

## Test plan
1. Default parameters, tready=1, samples 1,2,3,4 → m_tdata=0x04030201 with tlast=0; tvalid is high 2 cycles after the 4th handshake, for 1 cycle.
2. Samples −5,300,255,0 → 0x00FFFF00.
3. Samples 7, then 9 with tlast=1 → 0x00000907 with tlast=1; the next samples 1,2,3,4 → 0x04030201.
4. tready=0, 8 consecutive samples 1..8:
   - First word 0x04030201 is held stable.
   - Samples 5,6,7 are absorbed and 8 sits in stage C; all 8 are accepted and s_axis_a_tready=0 for the 9th.
   - Raise tready → 0x04030201, then 0x08070605 on the following handshakes; no loss or duplication.
5. Samples 1,2, then aresetn=0 for 1 cycle, then 5,6,7,8 → only 0x08070605 appears; tvalid=0 throughout reset.
6. Macro defined, samples −1,1000,5,6 → clamp_count=2 and word 0x0605FF00; macro undefined → the same word is produced.
